cpu_core_p: RTL and testbench
=============================

Name: cpu_core_p

Overview:
- Parametrised successor to the team's 8-bit mock-8080 core. It has configurable data and address width, selectable stepping mode, a stack, and a wider 8080-encoded instruction subset.
- Fetches from and stores to the shared single-port RAM over a one-tick-latency read, single-tick-write interface.
- Sits between the programming/reset logic and the RAM module.

Parameters:
- DW, 8: data/register width; opcodes occupy the low 8 bits of an instruction word (DW >= 8).
- AW, 8: address width; AW <= DW; address operands use the low AW bits of the fetched word.
- STEP_EDGE, 1: 1 = advance one tick per rising edge of step; 0 = advance on every clk_qzt while en.
- SP_INIT, all ones (AW bits): stack pointer value after reset.

Ports:
- clk_qzt, in, 1: system clock; all logic on its posedge.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: global enable; when low, no architectural state changes.
- step, in, 1: slave step strobe, edge-detected when STEP_EDGE=1; ignored when STEP_EDGE=0.
- res_addr, in, AW: PC value loaded on reset.
- data_in, in, DW: RAM read data, valid one tick after data_addr is presented.
- data_out, out, DW: RAM write data.
- data_addr, out, AW: RAM address.
- write_en, out, 1: RAM write strobe.
- halted, out, 1: high after HLT executes.

Behaviour:
- Tick definition:
  - A tick is a clk_qzt posedge with en=1 and (STEP_EDGE=0 or (step=1 and step_q=0)).
  - step_q <= step on every clk_qzt, regardless of en.
- Reset (priority over everything):
  - PC <= res_addr; SP <= SP_INIT; A, B, C, W, IR <= 0; carry, zero <= 0.
  - state <= F0; data_out, data_addr <= 0; write_en <= 0; halted <= 0.
  - Reset mid-write drops write_en on the same edge.
- States: F0, F1, E0, E1, E2, HALT.
  - F0: data_addr <= PC; write_en <= 0.
  - F1: IR <= data_in[7:0].
- Per-opcode behaviour (total latency in ticks, counted from F0):
  - 00 NOP, and any undefined opcode (3): PC += 1.
  - 06/0E/3E MVI B/C/A (4): E0 addr <= PC+1; E1 reg <= data_in, PC += 2.
  - 80/81 ADD B/C (3): {carry, A} <= A + r (DW+1-bit sum); zero <= (new A == 0); PC += 1.
  - 90 SUB B (3): {carry, A} <= {1'b0, A} - {1'b0, B}, so carry = borrow; zero updated; PC += 1.
  - C3 JMP (4): E0 addr <= PC+1; E1 PC <= data_in[AW-1:0].
  - DA JC / CA JZ (4): as JMP if flag = 1, else PC += 2.
  - 3A LDA (5): E0 addr <= PC+1; E1 W <= data_in, addr <= data_in; E2 A <= data_in, PC += 3... corrected: PC += 2.
  - 32 STA (5): E0 addr <= PC+1; E1 addr <= data_in, data_out <= A, write_en <= 1; E2 write_en <= 0, PC += 2.
  - C5 PUSH B (4): E0 SP <= SP-1, addr <= SP-1, data_out <= B, write_en <= 1; E1 write_en <= 0, PC += 1.
  - C1 POP B (4): E0 addr <= SP; E1 B <= data_in, SP <= SP+1, PC += 1.
  - CD CALL (5): E0 addr <= PC+1; E1 W <= data_in, SP <= SP-1, addr <= SP-1, data_out <= PC+2, write_en <= 1; E2 write_en <= 0, PC <= W.
  - C9 RET (4): E0 addr <= SP; E1 PC <= data_in, SP <= SP+1.
  - 76 HLT (3): halted <= 1; state <= HALT. HALT is left only by reset; PC is unchanged.
- Every instruction returns to F0 on its final tick.
- Write and flag rules:
  - write_en is high for exactly one tick per store; it never overlaps an instruction fetch.
  - Flags change only on ADD and SUB.
- Wrap-around:
  - PC and SP wrap modulo 2^AW, including PUSH at SP=0 and POP/RET at SP = all ones.
- Stalls:
  - en low or no step edge: all outputs and registers hold, including a pending write_en.

Test Plan:
- Reset with res_addr=0x10; RAM[0x10..]=3E 05 06 03 80 76 -> A=0x08, carry=0, zero=0, halted=1 at PC=0x15, after 4+4+3+3 = 14 ticks.
- A=0xFF, B=0x01, ADD B -> A=0x00, carry=1, zero=1; then JC 0x40 -> PC=0x40. With carry=0 instead, PC advances by 2.
- SP_INIT=0xFF; CALL 0x30 at PC=0x20; RAM[0x30]=C9 -> single write_en pulse with addr=0xFE, data_out=0x22; SP returns to 0xFF; PC returns to 0x22.
- STA 0x80 with A=0x5A, then LDA 0x80 after clearing A via MVI A,0 -> write_en high for exactly one tick; A=0x5A.
- STEP_EDGE=1 with step held high for 20 clocks -> exactly one tick. en=0 during E1 of STA -> write_en and data_addr hold until en returns.
- Reset asserted during E1 of PUSH (write_en=1) -> next clock write_en=0, PC=res_addr, SP=SP_INIT. Separately, run DW=16, AW=12, MVI B,0x1234 -> B=0x1234.

Source files
------------

// File: rtl/cpu_core_p.sv
// Parametrised mock-8080 core: 8080-encoded subset with stack, sharing a single-port RAM
// that has registered-address, one-tick read latency and single-tick writes.
module cpu_core_p #(
  parameter int              DW        = 8,
  parameter int              AW        = 8,
  parameter int              STEP_EDGE = 1,
  parameter logic [AW-1:0]   SP_INIT   = '1
) (
  input  logic          clk_qzt,
  input  logic          reset,
  input  logic          en,
  input  logic          step,
  input  logic [AW-1:0] res_addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic [AW-1:0] data_addr,
  output logic          write_en,
  output logic          halted
);

  typedef enum logic [2:0] {F0, F1, E0, E1, E2, HALT} state_t;

  localparam logic [7:0] OP_MVI_B = 8'h06;
  localparam logic [7:0] OP_MVI_C = 8'h0E;
  localparam logic [7:0] OP_MVI_A = 8'h3E;
  localparam logic [7:0] OP_ADD_B = 8'h80;
  localparam logic [7:0] OP_ADD_C = 8'h81;
  localparam logic [7:0] OP_SUB_B = 8'h90;
  localparam logic [7:0] OP_JMP   = 8'hC3;
  localparam logic [7:0] OP_JC    = 8'hDA;
  localparam logic [7:0] OP_JZ    = 8'hCA;
  localparam logic [7:0] OP_LDA   = 8'h3A;
  localparam logic [7:0] OP_STA   = 8'h32;
  localparam logic [7:0] OP_PUSH  = 8'hC5;
  localparam logic [7:0] OP_POP   = 8'hC1;
  localparam logic [7:0] OP_CALL  = 8'hCD;
  localparam logic [7:0] OP_RET   = 8'hC9;
  localparam logic [7:0] OP_HLT   = 8'h76;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n, sp, sp_n, addr_n;
  logic [DW-1:0] a, a_n, b, b_n, c, c_n, w, w_n, dout_n;
  logic [7:0]    ir, ir_n;
  logic          carry, carry_n, zero, zero_n, we_n, halted_n;
  logic          step_q, tick;

  logic [AW-1:0] pc_inc1, pc_inc2, sp_inc, sp_dec, operand;
  logic [DW-1:0] alu_rhs;
  logic [DW:0]   sum_add, diff_sub;

  // A tick is the only moment architectural state may move; step is edge-detected.
  assign tick     = en && ((STEP_EDGE == 0) || (step && !step_q));
  assign pc_inc1  = pc + AW'(1);
  assign pc_inc2  = pc + AW'(2);
  assign sp_inc   = sp + AW'(1);
  assign sp_dec   = sp - AW'(1);
  assign operand  = data_in[AW-1:0];
  assign alu_rhs  = (ir == OP_ADD_C) ? c : b;
  assign sum_add  = {1'b0, a} + {1'b0, alu_rhs};
  assign diff_sub = {1'b0, a} - {1'b0, b};

  always_ff @(posedge clk_qzt) step_q <= step;

  always_comb begin
    // NOTE: every next value defaults to "hold" before the case, so no path can infer a latch.
    state_n  = state;
    pc_n     = pc;
    sp_n     = sp;
    a_n      = a;
    b_n      = b;
    c_n      = c;
    w_n      = w;
    ir_n     = ir;
    carry_n  = carry;
    zero_n   = zero;
    dout_n   = data_out;
    addr_n   = data_addr;
    we_n     = write_en;
    halted_n = halted;

    case (state)
      F0: begin
        addr_n  = pc;
        we_n    = 1'b0;
        state_n = F1;
      end
      F1: begin
        ir_n    = data_in[7:0];
        state_n = E0;
      end
      E0: begin
        case (ir)
          OP_MVI_B, OP_MVI_C, OP_MVI_A, OP_JMP, OP_JC, OP_JZ,
          OP_LDA, OP_STA, OP_CALL: begin
            addr_n  = pc_inc1;
            state_n = E1;
          end
          OP_ADD_B, OP_ADD_C: begin
            {carry_n, a_n} = sum_add;
            zero_n         = (sum_add[DW-1:0] == '0);
            pc_n           = pc_inc1;
            state_n        = F0;
          end
          OP_SUB_B: begin
            {carry_n, a_n} = diff_sub;
            zero_n         = (diff_sub[DW-1:0] == '0);
            pc_n           = pc_inc1;
            state_n        = F0;
          end
          OP_PUSH: begin
            sp_n    = sp_dec;
            addr_n  = sp_dec;
            dout_n  = b;
            we_n    = 1'b1;
            state_n = E1;
          end
          OP_POP, OP_RET: begin
            addr_n  = sp;
            state_n = E1;
          end
          OP_HLT: begin
            halted_n = 1'b1;
            state_n  = HALT;
          end
          default: begin
            pc_n    = pc_inc1;
            state_n = F0;
          end
        endcase
      end
      E1: begin
        state_n = F0;
        case (ir)
          OP_MVI_B: begin b_n = data_in; pc_n = pc_inc2; end
          OP_MVI_C: begin c_n = data_in; pc_n = pc_inc2; end
          OP_MVI_A: begin a_n = data_in; pc_n = pc_inc2; end
          OP_JMP:   pc_n = operand;
          OP_JC:    pc_n = carry ? operand : pc_inc2;
          OP_JZ:    pc_n = zero  ? operand : pc_inc2;
          OP_LDA: begin
            w_n     = data_in;
            addr_n  = operand;
            state_n = E2;
          end
          OP_STA: begin
            addr_n  = operand;
            dout_n  = a;
            we_n    = 1'b1;
            state_n = E2;
          end
          OP_PUSH: begin
            we_n = 1'b0;
            pc_n = pc_inc1;
          end
          OP_POP: begin
            b_n  = data_in;
            sp_n = sp_inc;
            pc_n = pc_inc1;
          end
          OP_CALL: begin
            // Return address is pushed while the target is parked in W.
            w_n     = data_in;
            sp_n    = sp_dec;
            addr_n  = sp_dec;
            dout_n  = DW'(pc_inc2);
            we_n    = 1'b1;
            state_n = E2;
          end
          OP_RET: begin
            pc_n = operand;
            sp_n = sp_inc;
          end
          default: ;
        endcase
      end
      E2: begin
        state_n = F0;
        case (ir)
          OP_LDA: begin a_n = data_in; pc_n = pc_inc2; end
          OP_STA: begin we_n = 1'b0; pc_n = pc_inc2; end
          OP_CALL: begin we_n = 1'b0; pc_n = w[AW-1:0]; end
          default: ;
        endcase
      end
      HALT:    state_n = HALT;
      default: state_n = F0;
    endcase
  end

  always_ff @(posedge clk_qzt) begin
    if (reset) begin
      state     <= F0;
      pc        <= res_addr;
      sp        <= SP_INIT;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      w         <= '0;
      ir        <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      data_out  <= '0;
      data_addr <= '0;
      write_en  <= 1'b0;
      halted    <= 1'b0;
    end else if (tick) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state     <= state_n;
      pc        <= pc_n;
      sp        <= sp_n;
      a         <= a_n;
      b         <= b_n;
      c         <= c_n;
      w         <= w_n;
      ir        <= ir_n;
      carry     <= carry_n;
      zero      <= zero_n;
      data_out  <= dout_n;
      data_addr <= addr_n;
      write_en  <= we_n;
      halted    <= halted_n;
    end
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// Self-checking bench for cpu_core_p: directed scenarios plus random programs
// compared instruction-by-instruction against an ISA-level reference model.
module tb_cpu_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit core, stepped by edges of step
  logic       reset, en, step, write_en, halted;
  logic [7:0] res_addr, data_in, data_out, data_addr;
  logic [7:0] mem [256];

  assign data_in = mem[data_addr];
  always @(posedge clk) if (write_en) mem[data_addr] <= data_out;

  cpu_core_p #(.DW(8), .AW(8), .STEP_EDGE(1), .SP_INIT(8'hFF)) dut (
    .clk_qzt(clk), .reset(reset), .en(en), .step(step), .res_addr(res_addr),
    .data_in(data_in), .data_out(data_out), .data_addr(data_addr),
    .write_en(write_en), .halted(halted)
  );

  // 16-bit data / 12-bit address core, free-running on every clock
  logic        reset2, en2, step2, write_en2, halted2;
  logic [11:0] res_addr2, data_addr2;
  logic [15:0] data_in2, data_out2;
  logic [15:0] mem2 [4096];

  assign data_in2 = mem2[data_addr2];
  always @(posedge clk) if (write_en2) mem2[data_addr2] <= data_out2;

  cpu_core_p #(.DW(16), .AW(12), .STEP_EDGE(0), .SP_INIT(12'hFFF)) dut2 (
    .clk_qzt(clk), .reset(reset2), .en(en2), .step(step2), .res_addr(res_addr2),
    .data_in(data_in2), .data_out(data_out2), .data_addr(data_addr2),
    .write_en(write_en2), .halted(halted2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int wr_ticks;
  logic [7:0] wr_addr, wr_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One tick of the stepped core; records any store that is live during the tick.
  task automatic do_tick();
    @(negedge clk);
    if (write_en) begin
      wr_ticks++;
      wr_addr = data_addr;
      wr_data = data_out;
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic apply_reset(input logic [7:0] r);
    @(negedge clk);
    reset = 1'b1; res_addr = r; step = 1'b0; en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr_ticks = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // ---------------- ISA-level reference model ----------------
  logic [7:0] m_mem [256];
  logic [7:0] m_pc, m_sp, m_a, m_b, m_c;
  bit         m_cy, m_z, m_h;

  task automatic model_exec(output int lat, output int nwr);
    logic [7:0] op, nxt, opnd, t;
    int sum;
    op   = m_mem[m_pc];
    nxt  = m_pc + 8'd1;
    opnd = m_mem[nxt];
    nwr  = 0;
    lat  = 3;
    case (op)
      8'h06: begin m_b = opnd; m_pc = m_pc + 8'd2; lat = 4; end
      8'h0E: begin m_c = opnd; m_pc = m_pc + 8'd2; lat = 4; end
      8'h3E: begin m_a = opnd; m_pc = m_pc + 8'd2; lat = 4; end
      8'h80, 8'h81: begin
        sum  = int'(m_a) + int'((op == 8'h80) ? m_b : m_c);
        m_cy = (sum > 255);
        m_a  = 8'(sum % 256);
        m_z  = (m_a == 8'd0);
        m_pc = m_pc + 8'd1;
      end
      8'h90: begin
        m_cy = (m_b > m_a);
        m_a  = m_a - m_b;
        m_z  = (m_a == 8'd0);
        m_pc = m_pc + 8'd1;
      end
      8'hC3: begin m_pc = opnd; lat = 4; end
      8'hDA: begin m_pc = m_cy ? opnd : m_pc + 8'd2; lat = 4; end
      8'hCA: begin m_pc = m_z  ? opnd : m_pc + 8'd2; lat = 4; end
      8'h3A: begin m_a = m_mem[opnd]; m_pc = m_pc + 8'd2; lat = 5; end
      8'h32: begin m_mem[opnd] = m_a; m_pc = m_pc + 8'd2; lat = 5; nwr = 1; end
      8'hC5: begin m_sp = m_sp - 8'd1; m_mem[m_sp] = m_b; m_pc = m_pc + 8'd1; lat = 4; nwr = 1; end
      8'hC1: begin m_b = m_mem[m_sp]; m_sp = m_sp + 8'd1; m_pc = m_pc + 8'd1; lat = 4; end
      8'hCD: begin
        t = m_pc + 8'd2;
        m_sp = m_sp - 8'd1;
        m_mem[m_sp] = t;
        m_pc = opnd;
        lat = 5; nwr = 1;
      end
      8'hC9: begin m_pc = m_mem[m_sp]; m_sp = m_sp + 8'd1; lat = 4; end
      8'h76: m_h = 1'b1;
      default: m_pc = m_pc + 8'd1;
    endcase
  endtask

  localparam logic [7:0] OP_TAB [17] = '{8'h00, 8'h06, 8'h0E, 8'h3E, 8'h80, 8'h81, 8'h90,
    8'hC3, 8'hDA, 8'hCA, 8'h3A, 8'h32, 8'hC5, 8'hC1, 8'hCD, 8'hC9, 8'h76};

  task automatic gen_program();
    int addr;
    logic [7:0] op;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
    addr = 0;
    while (addr < 128) begin
      op = OP_TAB[$urandom_range(0, 16)];
      m_mem[addr] = op;
      case (op)
        8'h06, 8'h0E, 8'h3E: begin m_mem[addr+1] = 8'($urandom); addr += 2; end
        8'hC3, 8'hDA, 8'hCA, 8'hCD: begin m_mem[addr+1] = 8'($urandom_range(0, 127)); addr += 2; end
        8'h3A, 8'h32: begin m_mem[addr+1] = 8'($urandom_range(128, 255)); addr += 2; end
        default: addr += 1;
      endcase
    end
    for (int i = 0; i < 256; i++) mem[i] = m_mem[i];
  endtask

  task automatic run_random(input int n_prog);
    int lat, nwr, errs0, diffs;
    logic [7:0] r;
    for (int p = 0; p < n_prog; p++) begin
      gen_program();
      r = 8'($urandom_range(0, 127));
      m_pc = r; m_sp = 8'hFF; m_a = 0; m_b = 0; m_c = 0;
      m_cy = 0; m_z = 0; m_h = 0;
      apply_reset(r);
      check("rnd_rst_pc", dut.pc, m_pc);
      for (int k = 0; k < 60 && !m_h; k++) begin
        errs0 = n_errors;
        model_exec(lat, nwr);
        wr_ticks = 0;
        ticks(lat);
        check("rnd_pc", dut.pc, m_pc);
        check("rnd_a", dut.a, m_a);
        check("rnd_b", dut.b, m_b);
        check("rnd_c", dut.c, m_c);
        check("rnd_sp", dut.sp, m_sp);
        check("rnd_carry", dut.carry, m_cy);
        check("rnd_zero", dut.zero, m_z);
        check("rnd_halted", halted, m_h);
        check("rnd_wr_ticks", wr_ticks, nwr);
        if (n_errors != errs0) break;
      end
      if (m_h) begin
        ticks(3);
        check("rnd_halt_pc_hold", dut.pc, m_pc);
        check("rnd_halt_hold", halted, 1);
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) diffs++;
      check("rnd_mem_image", diffs, 0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; step = 1'b0; res_addr = 8'h00; wr_ticks = 0;
    reset2 = 1'b1; en2 = 1'b1; step2 = 1'b0; res_addr2 = 12'h100;
    clear_mem();
    for (int i = 0; i < 4096; i++) mem2[i] = 16'h0000;

    // Reset state and the MVI/MVI/ADD/HLT program
    mem[8'h10] = 8'h3E; mem[8'h11] = 8'h05; mem[8'h12] = 8'h06;
    mem[8'h13] = 8'h03; mem[8'h14] = 8'h80; mem[8'h15] = 8'h76;
    apply_reset(8'h10);
    check("rst_pc", dut.pc, 8'h10);
    check("rst_sp", dut.sp, 8'hFF);
    check("rst_a", dut.a, 0);
    check("rst_write_en", write_en, 0);
    check("rst_data_addr", data_addr, 0);
    check("rst_halted", halted, 0);
    ticks(13);
    check("prog1_not_yet_halted", halted, 0);
    ticks(1);
    check("prog1_a", dut.a, 8'h08);
    check("prog1_carry", dut.carry, 0);
    check("prog1_zero", dut.zero, 0);
    check("prog1_halted", halted, 1);
    check("prog1_pc", dut.pc, 8'h15);

    // ADD overflow then JC, taken and not taken
    clear_mem();
    mem[0] = 8'h3E; mem[1] = 8'hFF; mem[2] = 8'h06; mem[3] = 8'h01;
    mem[4] = 8'h80; mem[5] = 8'hDA; mem[6] = 8'h40; mem[8'h40] = 8'h76;
    apply_reset(8'h00);
    ticks(11);
    check("add_ovf_a", dut.a, 0);
    check("add_ovf_carry", dut.carry, 1);
    check("add_ovf_zero", dut.zero, 1);
    ticks(4);
    check("jc_taken_pc", dut.pc, 8'h40);
    mem[1] = 8'h01;
    apply_reset(8'h00);
    ticks(15);
    check("jc_not_taken_pc", dut.pc, 8'h07);
    check("add_small_a", dut.a, 8'h02);

    // CALL / RET
    clear_mem();
    mem[8'h20] = 8'hCD; mem[8'h21] = 8'h30; mem[8'h30] = 8'hC9;
    apply_reset(8'h20);
    ticks(5);
    check("call_wr_ticks", wr_ticks, 1);
    check("call_wr_addr", wr_addr, 8'hFE);
    check("call_wr_data", wr_data, 8'h22);
    check("call_sp", dut.sp, 8'hFE);
    check("call_pc", dut.pc, 8'h30);
    ticks(4);
    check("ret_pc", dut.pc, 8'h22);
    check("ret_sp", dut.sp, 8'hFF);
    check("ret_no_extra_write", wr_ticks, 1);

    // STA then LDA through a cleared A
    clear_mem();
    mem[0] = 8'h3E; mem[1] = 8'h5A; mem[2] = 8'h32; mem[3] = 8'h80;
    mem[4] = 8'h3E; mem[5] = 8'h00; mem[6] = 8'h3A; mem[7] = 8'h80; mem[8] = 8'h76;
    apply_reset(8'h00);
    ticks(9);
    check("sta_wr_ticks", wr_ticks, 1);
    check("sta_mem", mem[8'h80], 8'h5A);
    ticks(4);
    check("mvi_clear_a", dut.a, 0);
    ticks(5);
    check("lda_a", dut.a, 8'h5A);
    check("lda_no_write", wr_ticks, 1);

    // step held high counts as a single tick
    clear_mem();
    apply_reset(8'h33);
    @(negedge clk); step = 1'b1;
    repeat (20) @(negedge clk);
    step = 1'b0;
    check("hold_data_addr", data_addr, 8'h33);
    check("hold_pc", dut.pc, 8'h33);
    ticks(1);
    check("hold_pc_after_f1", dut.pc, 8'h33);
    ticks(1);
    check("hold_pc_after_e0", dut.pc, 8'h34);

    // en low freezes a pending store
    clear_mem();
    mem[0] = 8'h3E; mem[1] = 8'h5A; mem[2] = 8'h32; mem[3] = 8'h80; mem[4] = 8'h76;
    apply_reset(8'h00);
    ticks(8);
    check("stall_pre_we", write_en, 1);
    @(negedge clk); en = 1'b0;
    ticks(5);
    check("stall_we", write_en, 1);
    check("stall_addr", data_addr, 8'h80);
    check("stall_dout", data_out, 8'h5A);
    check("stall_pc", dut.pc, 8'h02);
    @(negedge clk); en = 1'b1;
    ticks(1);
    check("stall_release_we", write_en, 0);
    check("stall_release_pc", dut.pc, 8'h04);

    // Reset lands mid-PUSH, with en low as well
    clear_mem();
    mem[0] = 8'h06; mem[1] = 8'h77; mem[2] = 8'hC5;
    apply_reset(8'h00);
    ticks(7);
    check("push_we_live", write_en, 1);
    check("push_addr", data_addr, 8'hFE);
    @(negedge clk); reset = 1'b1; en = 1'b0; res_addr = 8'h50;
    @(negedge clk);
    check("push_rst_we", write_en, 0);
    check("push_rst_pc", dut.pc, 8'h50);
    check("push_rst_sp", dut.sp, 8'hFF);
    reset = 1'b0; en = 1'b1;

    // Wide configuration: DW=16, AW=12, free-running
    mem2[12'h100] = 16'h5506; mem2[12'h101] = 16'h1234;
    mem2[12'h102] = 16'h003E; mem2[12'h103] = 16'hEDCC;
    mem2[12'h104] = 16'h0080; mem2[12'h105] = 16'h00C3;
    mem2[12'h106] = 16'hF800; mem2[12'h800] = 16'h0076;
    @(negedge clk);
    check("w16_rst_pc", dut2.pc, 12'h100);
    check("w16_rst_sp", dut2.sp, 12'hFFF);
    reset2 = 1'b0;
    repeat (4) @(negedge clk);
    check("w16_mvi_b", dut2.b, 16'h1234);
    check("w16_mvi_pc", dut2.pc, 12'h102);
    repeat (14) @(negedge clk);
    check("w16_add_a", dut2.a, 0);
    check("w16_add_carry", dut2.carry, 1);
    check("w16_add_zero", dut2.zero, 1);
    check("w16_jmp_pc", dut2.pc, 12'h800);
    check("w16_halted", halted2, 1);

    // Randomised programs against the ISA model
    run_random(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
